burst_scheduler: RTL and testbench
==================================

BURST_SCHEDULER -- requirements
Module: burst_scheduler

Interface
REQ-001 SHALL have parameter HALF_W, default 8: width of the tone half-period field.
REQ-002 SHALL have parameter NCYC_W, default 8: width of the burst cycle-count field.
REQ-003 SHALL have parameter PRI_W, default 16: width of the pulse-repetition-interval field.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port cfg_word, input, 32: configuration from the 32-bit serial input register. Bits [7:0] are half_period, [15:8] are n_cycles, [31:16] are pri_period.
REQ-007 SHALL have port cfg_load, input, 1: one-cycle strobe that captures cfg_word into the shadow register.
REQ-008 SHALL have port run, input, 1: level; 1 requests continuous pulse repetition.
REQ-009 SHALL have port burst_pos, output, 1: positive transducer drive.
REQ-010 SHALL have port burst_neg, output, 1: negative transducer drive.
REQ-011 SHALL have port rx_gate, output, 1: receive window; high during LISTEN.
REQ-012 SHALL have port pri_tick, output, 1: one-cycle pulse in the first cycle of each BURST state.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port overrun, output, 1: sticky; set when a burst outlasts pri_period.

Function
REQ-015 SHALL implement the states IDLE, BURST and LISTEN, held in a registered state variable.
REQ-016 IDLE->BURST SHALL occur on the clock edge where run=1; the active register is loaded from the shadow register on that same edge.
REQ-017 In BURST, the outputs SHALL be registered as follows: burst_pos=1 for half_period cycles, then burst_neg=1 for half_period cycles; this repeats n_cycles times. burst_pos and burst_neg SHALL never be high together.
REQ-018 The first burst_pos cycle SHALL be the cycle in which pri_tick=1, which is one cycle after run is sampled in IDLE.
REQ-019 A half_period of 0 SHALL be treated as 1.
REQ-020 A n_cycles of 0 SHALL mean BURST lasts 1 cycle with both drives low; pri_tick still pulses.
REQ-021 The PRI counter SHALL count clk cycles from the pri_tick cycle, starting at 0.
REQ-022 BURST->LISTEN SHALL occur after the last burst_neg cycle.
REQ-023 LISTEN SHALL end when the PRI counter reaches pri_period-1. It then goes to BURST if run=1 (reloading active config, pulse pri_tick), otherwise to IDLE.
REQ-024 If the PRI counter reaches pri_period-1 while in BURST, the burst SHALL complete, overrun SHALL set, and LISTEN SHALL last exactly 1 cycle.
REQ-025 A pri_period of 0 SHALL be treated as 1.
REQ-026 A cfg_load at any time SHALL update only the shadow register; the active config never changes mid-PRI.
REQ-027 A cfg_load in the same cycle as a reload SHALL take effect in the following PRI, not the current one.
REQ-028 run deasserted mid-PRI SHALL let the current PRI finish; there is no truncation.
REQ-029 overrun SHALL clear only on reset or on cfg_load.

Reset
REQ-030 Reset SHALL force state=IDLE and all counters=0.
REQ-031 Reset SHALL clear the shadow and active registers (half_period=0, n_cycles=0, pri_period=0).
REQ-032 Reset SHALL set burst_pos=burst_neg=rx_gate=pri_tick=busy=overrun=0, asynchronously, including in the middle of a burst.

Structure
REQ-033 A shared package SHALL hold the state enum, the cfg_word field offsets and widths, and the default parameter values.
REQ-034 The half-period/cycle counter pair SHALL be one sub-module, tone_sequencer, with start input, done output and pos/neg outputs. The PRI counter and FSM SHALL stay in the top level.

Verification
REQ-035 Basic burst: half_period=2, n_cycles=3, pri_period=20, run held high. burst_pos SHALL be high in PRI cycles 0-1, 4-5 and 8-9; burst_neg in 2-3, 6-7 and 10-11; rx_gate in 12-19; pri_tick every 20 cycles.
REQ-036 Overrun: half_period=4, n_cycles=4, pri_period=10. The burst SHALL run 32 cycles, then LISTEN 1 cycle; overrun=1; the next pri_tick SHALL come at cycle 33.
REQ-037 Shadow update: cfg_load with half_period=1 during a PRI configured with half_period=3. The current burst SHALL keep 3-cycle halves; the next PRI SHALL use 1-cycle halves.
REQ-038 Stop: run dropped during BURST. The PRI SHALL finish, then IDLE with busy=0; no further pri_tick.
REQ-039 Zero fields: n_cycles=0 and pri_period=0. Each PRI SHALL be BURST 1 cycle plus LISTEN 1 cycle; drives stay low; no X on any output.
REQ-040 Async reset mid-burst, asserted between clock edges. All outputs SHALL go to 0 immediately; after release with run=1, the first pri_tick SHALL come 1 cycle after run is sampled, using the reset config (all zeros).

Source files
------------

// File: rtl/burst_scheduler_pkg.sv
// Shared types and constants for the ultrasonic burst scheduler.
// Holds the state encoding, the cfg_word field layout and the default widths.
package burst_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_LISTEN = 2'd2
  } state_e;

  localparam int HALF_W_DEF = 8;
  localparam int NCYC_W_DEF = 8;
  localparam int PRI_W_DEF  = 16;

  localparam int CFG_W    = 32;
  localparam int HALF_LSB = 0;
  localparam int NCYC_LSB = 8;
  localparam int PRI_LSB  = 16;

endpackage

// File: rtl/burst_scheduler_tone_sequencer.sv
// Tone sequencer: half-period and cycle counters producing registered pos/neg
// drives; done is high in the final burst cycle so the parent can leave BURST.
module tone_sequencer import burst_scheduler_pkg::*; #(
  parameter int HALF_W = HALF_W_DEF,
  parameter int NCYC_W = NCYC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [HALF_W-1:0] half_period,
  input  logic [NCYC_W-1:0] n_cycles,
  output logic              pos,
  output logic              neg,
  output logic              done
);

  logic              run_q, run_d;
  logic              phase_q, phase_d;
  logic              pos_q, pos_d;
  logic              neg_q, neg_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic [NCYC_W-1:0] cyc_cnt_q, cyc_cnt_d;

  logic [HALF_W-1:0] half_max;
  logic              ncyc_zero;
  logic              half_end;
  logic              cyc_last;

  // A zero half-period behaves as one cycle per half.
  assign half_max  = (half_period == '0) ? '0 : half_period - HALF_W'(1);
  assign ncyc_zero = (n_cycles == '0);
  assign half_end  = (half_cnt_q == half_max);
  assign cyc_last  = (cyc_cnt_q == n_cycles - NCYC_W'(1));
  assign done      = run_q & (ncyc_zero | (phase_q & half_end & cyc_last));

  always_comb begin
    run_d      = run_q;
    phase_d    = phase_q;
    half_cnt_d = half_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    pos_d      = 1'b0;
    neg_d      = 1'b0;
    if (start) begin
      run_d      = 1'b1;
      phase_d    = 1'b0;
      half_cnt_d = '0;
      cyc_cnt_d  = '0;
      pos_d      = ~ncyc_zero;
    end else if (run_q) begin
      if (done) begin
        run_d = 1'b0;
      end else begin
        if (half_end) begin
          half_cnt_d = '0;
          phase_d    = ~phase_q;
          if (phase_q) cyc_cnt_d = cyc_cnt_q + NCYC_W'(1);
        end else begin
          half_cnt_d = half_cnt_q + HALF_W'(1);
        end
        pos_d = ~phase_d;
        neg_d = phase_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q      <= 1'b0;
      phase_q    <= 1'b0;
      half_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      pos_q      <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      run_q      <= run_d;
      phase_q    <= phase_d;
      half_cnt_q <= half_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      pos_q      <= pos_d;
      neg_q      <= neg_d;
    end
  end

  assign pos = pos_q;
  assign neg = neg_q;

endmodule

// File: rtl/burst_scheduler.sv
// Burst scheduler top: IDLE/BURST/LISTEN FSM, PRI counter, shadow/active config
// and sticky overrun flag; tone generation lives in tone_sequencer.
module burst_scheduler import burst_scheduler_pkg::*; #(
  parameter int HALF_W = HALF_W_DEF,
  parameter int NCYC_W = NCYC_W_DEF,
  parameter int PRI_W  = PRI_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CFG_W-1:0] cfg_word,
  input  logic             cfg_load,
  input  logic             run,
  output logic             burst_pos,
  output logic             burst_neg,
  output logic             rx_gate,
  output logic             pri_tick,
  output logic             busy,
  output logic             overrun
);

  state_e            state_q, state_d;
  logic [PRI_W-1:0]  pri_cnt_q, pri_cnt_d;
  logic              hit_q, hit_d;
  logic              overrun_q, overrun_d;
  logic              pri_tick_q, pri_tick_d;
  logic              rx_gate_q, rx_gate_d;
  logic              busy_q, busy_d;

  logic [HALF_W-1:0] sh_half_q, sh_half_d, act_half_q, act_half_d;
  logic [NCYC_W-1:0] sh_ncyc_q, sh_ncyc_d, act_ncyc_q, act_ncyc_d;
  logic [PRI_W-1:0]  sh_pri_q,  sh_pri_d,  act_pri_q,  act_pri_d;

  logic [PRI_W-1:0]  pri_max;
  logic              pri_end;
  logic              reload;
  logic              seq_done;
  logic [HALF_W-1:0] seq_half;
  logic [NCYC_W-1:0] seq_ncyc;

  // hit_q remembers that the PRI already expired during the burst.
  assign pri_max  = (act_pri_q == '0) ? '0 : act_pri_q - PRI_W'(1);
  assign pri_end  = hit_q | (pri_cnt_q == pri_max);
  assign reload   = run & ((state_q == ST_IDLE) | ((state_q == ST_LISTEN) & pri_end));
  assign seq_half = reload ? sh_half_q : act_half_q;
  assign seq_ncyc = reload ? sh_ncyc_q : act_ncyc_q;

  tone_sequencer #(.HALF_W(HALF_W), .NCYC_W(NCYC_W)) u_tone (
    .clk         (clk),
    .reset       (reset),
    .start       (reload),
    .half_period (seq_half),
    .n_cycles    (seq_ncyc),
    .pos         (burst_pos),
    .neg         (burst_neg),
    .done        (seq_done)
  );

  always_comb begin
    state_d    = state_q;
    pri_cnt_d  = pri_cnt_q;
    hit_d      = hit_q;
    overrun_d  = overrun_q;
    sh_half_d  = sh_half_q;
    sh_ncyc_d  = sh_ncyc_q;
    sh_pri_d   = sh_pri_q;
    act_half_d = act_half_q;
    act_ncyc_d = act_ncyc_q;
    act_pri_d  = act_pri_q;
    if (cfg_load) begin
      sh_half_d = cfg_word[HALF_LSB +: HALF_W];
      sh_ncyc_d = cfg_word[NCYC_LSB +: NCYC_W];
      sh_pri_d  = cfg_word[PRI_LSB  +: PRI_W];
      overrun_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: ;
      ST_BURST: begin
        pri_cnt_d = pri_cnt_q + PRI_W'(1);
        // A fresh overrun wins over a simultaneous cfg_load clear.
        if (pri_cnt_q == pri_max) begin
          hit_d     = 1'b1;
          overrun_d = 1'b1;
        end
        if (seq_done) state_d = ST_LISTEN;
      end
      ST_LISTEN: begin
        if (pri_end) begin
          state_d   = ST_IDLE;
          pri_cnt_d = '0;
          hit_d     = 1'b0;
        end else begin
          pri_cnt_d = pri_cnt_q + PRI_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (reload) begin
      state_d    = ST_BURST;
      pri_cnt_d  = '0;
      hit_d      = 1'b0;
      act_half_d = sh_half_q;
      act_ncyc_d = sh_ncyc_q;
      act_pri_d  = sh_pri_q;
    end
    pri_tick_d = reload;
    rx_gate_d  = (state_d == ST_LISTEN);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pri_cnt_q  <= '0;
      hit_q      <= 1'b0;
      overrun_q  <= 1'b0;
      pri_tick_q <= 1'b0;
      rx_gate_q  <= 1'b0;
      busy_q     <= 1'b0;
      sh_half_q  <= '0;
      sh_ncyc_q  <= '0;
      sh_pri_q   <= '0;
      act_half_q <= '0;
      act_ncyc_q <= '0;
      act_pri_q  <= '0;
    end else begin
      state_q    <= state_d;
      pri_cnt_q  <= pri_cnt_d;
      hit_q      <= hit_d;
      overrun_q  <= overrun_d;
      pri_tick_q <= pri_tick_d;
      rx_gate_q  <= rx_gate_d;
      busy_q     <= busy_d;
      sh_half_q  <= sh_half_d;
      sh_ncyc_q  <= sh_ncyc_d;
      sh_pri_q   <= sh_pri_d;
      act_half_q <= act_half_d;
      act_ncyc_q <= act_ncyc_d;
      act_pri_q  <= act_pri_d;
    end
  end

  assign pri_tick = pri_tick_q;
  assign rx_gate  = rx_gate_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_burst_scheduler.sv
// Bench for burst_scheduler: PRI-timeline reference model checked every cycle,
// directed scenarios pinned with literal expectations, then random traffic.
module tb_burst_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cfg_word;
  logic        cfg_load;
  logic        run;
  logic        burst_pos, burst_neg, rx_gate, pri_tick, busy, overrun;

  always #5 clk = ~clk;

  burst_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_word  (cfg_word),
    .cfg_load  (cfg_load),
    .run       (run),
    .burst_pos (burst_pos),
    .burst_neg (burst_neg),
    .rx_gate   (rx_gate),
    .pri_tick  (pri_tick),
    .busy      (busy),
    .overrun   (overrun)
  );

  int checks = 0;
  int errors = 0;

  // Model: a PRI is a timeline of cycles k = 0..T-1 with the burst in k < L.
  bit m_active, m_ovr;
  int m_k, m_L, m_P, m_h, m_n;
  int sh_half, sh_n, sh_pri;

  localparam int LOGN = 256;
  bit lg_pos[LOGN], lg_neg[LOGN], lg_rx[LOGN], lg_tick[LOGN], lg_busy[LOGN], lg_ovr[LOGN];
  int lg_n;

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b exp %b", name, $time, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d exp %0d", name, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_k = 0; m_ovr = 0;
    m_L = 1; m_P = 1; m_h = 1; m_n = 0;
    sh_half = 0; sh_n = 0; sh_pri = 0;
  endfunction

  function automatic void start_pri();
    m_active = 1;
    m_k = 0;
    m_h = (sh_half == 0) ? 1 : sh_half;
    m_n = sh_n;
    m_P = (sh_pri == 0) ? 1 : sh_pri;
    m_L = (m_n == 0) ? 1 : 2 * m_h * m_n;
  endfunction

  function automatic void model_edge();
    bit set_ovr;
    int t_len;
    set_ovr = 0;
    if (m_active) begin
      set_ovr = (m_k == m_P - 1) && (m_k < m_L);
      t_len = (m_L >= m_P) ? m_L + 1 : m_P;
      if (m_k == t_len - 1) begin
        if (run) start_pri();
        else m_active = 0;
      end else begin
        m_k++;
      end
    end else if (run) begin
      start_pri();
    end
    if (set_ovr) m_ovr = 1;
    else if (cfg_load) m_ovr = 0;
    if (cfg_load) begin
      sh_half = int'(cfg_word[7:0]);
      sh_n    = int'(cfg_word[15:8]);
      sh_pri  = int'(cfg_word[31:16]);
    end
  endfunction

  task automatic compare();
    bit inb, e_pos, e_neg;
    inb   = m_active && (m_k < m_L);
    e_pos = inb && (m_n > 0) && ((m_k % (2 * m_h)) < m_h);
    e_neg = inb && (m_n > 0) && !e_pos;
    chk("pos",  burst_pos, e_pos);
    chk("neg",  burst_neg, e_neg);
    chk("rx",   rx_gate,   m_active && (m_k >= m_L));
    chk("tick", pri_tick,  m_active && (m_k == 0));
    chk("busy", busy,      m_active);
    chk("ovr",  overrun,   m_ovr);
    if (lg_n < LOGN) begin
      lg_pos[lg_n] = burst_pos; lg_neg[lg_n] = burst_neg; lg_rx[lg_n] = rx_gate;
      lg_tick[lg_n] = pri_tick; lg_busy[lg_n] = busy; lg_ovr[lg_n] = overrun;
      lg_n++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic load(input logic [15:0] pri, input logic [7:0] n, input logic [7:0] h);
    cfg_word = {pri, n, h};
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic go_idle();
    int i;
    run = 1'b0;
    i = 0;
    while (m_active && i < 2000) begin
      step();
      i++;
    end
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_pos"},  burst_pos, 1'b0);
    chk({tag, "_neg"},  burst_neg, 1'b0);
    chk({tag, "_rx"},   rx_gate,   1'b0);
    chk({tag, "_tick"}, pri_tick,  1'b0);
    chk({tag, "_busy"}, busy,      1'b0);
    chk({tag, "_ovr"},  overrun,   1'b0);
  endtask

  initial begin
    int nt;
    reset = 1'b1; run = 1'b0; cfg_load = 1'b0; cfg_word = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b0;

    // Basic burst: h=2 n=3 pri=20
    load(16'd20, 8'd3, 8'd2);
    run = 1'b1; lg_n = 0;
    steps(45);
    chk("basic_pos0",  lg_pos[0],  1'b1);
    chk("basic_pos5",  lg_pos[5],  1'b1);
    chk("basic_pos9",  lg_pos[9],  1'b1);
    chk("basic_neg2",  lg_neg[2],  1'b1);
    chk("basic_neg11", lg_neg[11], 1'b1);
    chk("basic_rx11",  lg_rx[11],  1'b0);
    chk("basic_rx12",  lg_rx[12],  1'b1);
    chk("basic_rx19",  lg_rx[19],  1'b1);
    chk("basic_tick19", lg_tick[19], 1'b0);
    chk("basic_tick20", lg_tick[20], 1'b1);
    chk("basic_tick40", lg_tick[40], 1'b1);
    go_idle();

    // Overrun: h=4 n=4 pri=10
    load(16'd10, 8'd4, 8'd4);
    run = 1'b1; lg_n = 0;
    steps(40);
    chk("ovr_neg31",  lg_neg[31],  1'b1);
    chk("ovr_rx32",   lg_rx[32],   1'b1);
    chk("ovr_tick32", lg_tick[32], 1'b0);
    chk("ovr_tick33", lg_tick[33], 1'b1);
    chk("ovr_flag9",  lg_ovr[9],   1'b0);
    chk("ovr_flag10", lg_ovr[10],  1'b1);
    go_idle();

    // Shadow update mid-PRI: h=3 then h=1
    load(16'd40, 8'd2, 8'd3);
    run = 1'b1; lg_n = 0;
    steps(5);
    cfg_word = {16'd40, 8'd2, 8'd1};
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    steps(40);
    chk("shd_pos2",   lg_pos[2],   1'b1);
    chk("shd_neg3",   lg_neg[3],   1'b1);
    chk("shd_neg5",   lg_neg[5],   1'b1);
    chk("shd_tick40", lg_tick[40], 1'b1);
    chk("shd_neg41",  lg_neg[41],  1'b1);
    chk("shd_pos42",  lg_pos[42],  1'b1);
    go_idle();

    // Stop during burst
    load(16'd20, 8'd3, 8'd2);
    run = 1'b1; lg_n = 0;
    steps(3);
    run = 1'b0;
    steps(30);
    chk("stop_busy19", lg_busy[19], 1'b1);
    chk("stop_busy20", lg_busy[20], 1'b0);
    nt = 0;
    for (int i = 0; i < 33; i++) nt += lg_tick[i];
    chk_int("stop_ticks", nt, 1);

    // Zero fields
    load(16'd0, 8'd0, 8'd0);
    run = 1'b1; lg_n = 0;
    steps(6);
    chk("zero_tick0", lg_tick[0], 1'b1);
    chk("zero_pos0",  lg_pos[0],  1'b0);
    chk("zero_rx1",   lg_rx[1],   1'b1);
    chk("zero_tick2", lg_tick[2], 1'b1);
    chk("zero_ovr1",  lg_ovr[1],  1'b1);
    go_idle();

    // Async reset mid-burst
    load(16'd20, 8'd3, 8'd2);
    run = 1'b1;
    steps(3);
    #2 reset = 1'b1;
    #1 chk_zero_outputs("areset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run = 1'b1; lg_n = 0;
    steps(5);
    chk("arst_tick0", lg_tick[0], 1'b1);
    chk("arst_pos0",  lg_pos[0],  1'b0);
    chk("arst_rx1",   lg_rx[1],   1'b1);
    chk("arst_tick2", lg_tick[2], 1'b1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 4) begin
        cfg_word = {16'($urandom_range(40)), 8'($urandom_range(3)), 8'($urandom_range(3))};
        cfg_load = 1'b1;
      end else begin
        cfg_load = 1'b0;
      end
      if ($urandom_range(99) < 3) run = ~run;
      step();
    end
    cfg_load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
